// File: rtl/spi_cmd_master_pkg.sv
// ---------------------------------------------------------------------------
// crapsynth_spi_pkg
// Shared definitions for the 24-bit noise/synth SPI command link.
//   WORD_BITS      bits per frame
//   CMD_LFSR_BIT   set = LFSR seed load, clear = freq_div load
//   FREQ_DIV_BITS  width of the freq_div payload (bits 16:0)
//   LFSR_BITS      width of the seed payload (bits 22:0)
//   spi_state_e    master FSM state encoding
//   mk_freq_cmd()  builds a freq_div load word
//   mk_seed_cmd()  builds an LFSR seed load word
// ---------------------------------------------------------------------------
package crapsynth_spi_pkg;

    localparam int WORD_BITS     = 24;
    localparam int CMD_LFSR_BIT  = 23;
    localparam int FREQ_DIV_BITS = 17;
    localparam int LFSR_BITS     = 23;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_e;

    // Command bit clear, unused middle bits zero, divider in the low bits.
    function automatic logic [WORD_BITS-1:0] mk_freq_cmd(input logic [FREQ_DIV_BITS-1:0] div);
        logic [WORD_BITS-1:0] w;
        w = '0;
        w[FREQ_DIV_BITS-1:0] = div;
        return w;
    endfunction

    // Command bit set, seed fills everything below it.
    function automatic logic [WORD_BITS-1:0] mk_seed_cmd(input logic [LFSR_BITS-1:0] seed);
        logic [WORD_BITS-1:0] w;
        w = '0;
        w[CMD_LFSR_BIT]       = 1'b1;
        w[LFSR_BITS-1:0]      = seed;
        return w;
    endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// ---------------------------------------------------------------------------
// spi_cmd_master_if
// Bundles the word handshake and the SPI pins of spi_cmd_master.
//   tx_data/tx_valid/tx_ready  word request handshake
//   tx_done/busy               frame status
//   spi_clock/spi_data/spi_cs  SPI mode-0 pins (cs active low)
// Modports: master = the SPI master block, slave = the word source.
// ---------------------------------------------------------------------------
interface spi_cmd_master_if #(
    parameter int WORD_BITS = crapsynth_spi_pkg::WORD_BITS
) ();

    logic [WORD_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_done;
    logic                 busy;
    logic                 spi_clock;
    logic                 spi_data;
    logic                 spi_cs;

    modport master (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, busy, spi_clock, spi_data, spi_cs
    );

    modport slave (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, busy, spi_clock, spi_data, spi_cs
    );

endinterface

// File: rtl/spi_cmd_master_phase_timer.sv
// ---------------------------------------------------------------------------
// spi_phase_timer
// Down-counter timing one spi_clock half-period (CLK_DIV sys_clk cycles).
//   sys_clk   in  clock
//   sys_rst   in  synchronous active-high reset
//   i_load    in  restart the period (counter <= CLK_DIV-1)
//   o_expire  out high on the last cycle of the period
// The counter stops at zero rather than wrapping.
// ---------------------------------------------------------------------------
module spi_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic i_load,
    output logic o_expire
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_count;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CW'(CLK_DIV - 1);
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_expire = (r_count == '0);

endmodule

// File: rtl/spi_cmd_master.sv
// ---------------------------------------------------------------------------
// spi_cmd_master
// Serialises one WORD_BITS command word MSB-first per spi_cs-low frame.
// Data is set up a full half-period before each spi_clock rising edge and
// held a full half-period after it; the receiver commits on spi_cs rising.
//   sys_clk  in   system clock
//   sys_rst  in   synchronous active-high reset (aborts any frame)
//   bus      master modport: tx_data/tx_valid in; tx_ready, tx_done, busy,
//            spi_clock, spi_data, spi_cs out (all registered)
// ---------------------------------------------------------------------------
module spi_cmd_master #(
    parameter int WORD_BITS = crapsynth_spi_pkg::WORD_BITS,
    parameter int CLK_DIV   = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    spi_cmd_master_if.master bus
);

    import crapsynth_spi_pkg::*;

    localparam int BW = $clog2(WORD_BITS);
    localparam int GW = $clog2(GAP_CYC + 1);

    spi_state_e           r_state;
    spi_state_e           w_state_next;

    logic [WORD_BITS-1:0] r_shreg;
    logic [BW-1:0]        r_bitcnt;
    logic [GW-1:0]        r_gapcnt;

    logic                 r_spi_cs,    w_spi_cs_next;
    logic                 r_spi_clock, w_spi_clock_next;
    logic                 r_tx_ready,  w_tx_ready_next;
    logic                 r_busy,      w_busy_next;
    logic                 r_tx_done,   w_tx_done_next;

    logic                 w_accept;
    logic                 w_last_bit;
    logic                 w_gap_expire;
    logic                 w_phase_load;
    logic                 w_phase_expire;

    assign w_accept     = bus.tx_valid && r_tx_ready;
    assign w_last_bit   = (r_bitcnt == BW'(WORD_BITS - 1));
    assign w_gap_expire = (r_gapcnt == '0);
    // Every timed state exits to a different state, so a state change is
    // exactly the moment a fresh half-period starts.
    assign w_phase_load = (w_state_next != r_state);

    spi_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .i_load   (w_phase_load),
        .o_expire (w_phase_expire)
    );

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)       w_state_next = ST_SETUP;
            ST_SETUP: if (w_phase_expire) w_state_next = ST_HIGH;
            ST_HIGH:  if (w_phase_expire) w_state_next = w_last_bit ? ST_HOLD : ST_LOW;
            ST_LOW:   if (w_phase_expire) w_state_next = ST_HIGH;
            ST_HOLD:  if (w_phase_expire) w_state_next = ST_GAP;
            ST_GAP:   if (w_gap_expire)   w_state_next = ST_IDLE;
            default:                      w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: computed from the state being entered so every output
    // is a register that changes on the same edge as the state.
    always_comb begin
        w_spi_cs_next    = 1'b1;
        w_spi_clock_next = 1'b0;
        w_tx_ready_next  = 1'b0;
        w_busy_next      = 1'b1;
        w_tx_done_next   = 1'b0;
        case (w_state_next)
            ST_SETUP, ST_LOW, ST_HOLD: w_spi_cs_next = 1'b0;
            ST_HIGH: begin
                w_spi_cs_next    = 1'b0;
                w_spi_clock_next = 1'b1;
            end
            ST_IDLE: begin
                w_tx_ready_next = 1'b1;
                w_busy_next     = 1'b0;
            end
            default: ;
        endcase
        if ((r_state == ST_HOLD) && (w_state_next == ST_GAP)) begin
            w_tx_done_next = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_spi_cs    <= 1'b1;
            r_spi_clock <= 1'b0;
            r_tx_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_spi_cs    <= w_spi_cs_next;
            r_spi_clock <= w_spi_clock_next;
            r_tx_ready  <= w_tx_ready_next;
            r_busy      <= w_busy_next;
            r_tx_done   <= w_tx_done_next;
        end
    end

    // Shift register, bit counter and gap counter. spi_data is taken straight
    // from the shift register MSB: loading on accept presents bit 23 as cs
    // falls, and the shift on HIGH->LOW presents the next bit as clock falls.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_gapcnt <= '0;
        end else begin
            if (r_state == ST_IDLE && w_accept) begin
                r_shreg  <= bus.tx_data;
                r_bitcnt <= '0;
            end else if (r_state == ST_HIGH && w_state_next == ST_LOW) begin
                r_shreg  <= {r_shreg[WORD_BITS-2:0], 1'b0};
                r_bitcnt <= r_bitcnt + BW'(1);
            end

            if (r_state == ST_HOLD && w_state_next == ST_GAP) begin
                r_gapcnt <= GW'(GAP_CYC - 1);
            end else if (r_state == ST_GAP && !w_gap_expire) begin
                r_gapcnt <= r_gapcnt - GW'(1);
            end
        end
    end

    assign bus.spi_cs    = r_spi_cs;
    assign bus.spi_clock = r_spi_clock;
    assign bus.spi_data  = r_shreg[WORD_BITS-1];
    assign bus.tx_ready  = r_tx_ready;
    assign bus.busy      = r_busy;
    assign bus.tx_done   = r_tx_done;

endmodule

// File: tb/tb_spi_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_master
// Two instances: dut0 at CLK_DIV=4/GAP_CYC=4, dut1 at CLK_DIV=3/GAP_CYC=1.
// Expected words go into a per-instance queue when driven; a sampler per
// instance rebuilds each frame from the SPI pins and compares on spi_cs rise.
// ---------------------------------------------------------------------------
module tb_spi_cmd_master;

    import crapsynth_spi_pkg::*;

    logic sys_clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 sys_clk = ~sys_clk;

    spi_cmd_master_if bus0 ();
    spi_cmd_master_if bus1 ();

    spi_cmd_master #(.WORD_BITS(24), .CLK_DIV(4), .GAP_CYC(4)) dut0 (
        .sys_clk (sys_clk),
        .sys_rst (rst0),
        .bus     (bus0.master)
    );

    spi_cmd_master #(.WORD_BITS(24), .CLK_DIV(3), .GAP_CYC(1)) dut1 (
        .sys_clk (sys_clk),
        .sys_rst (rst1),
        .bus     (bus1.master)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic m_cs[2], m_sclk[2], m_sd[2], m_done[2], m_ready[2];
    assign m_cs[0]    = bus0.spi_cs;
    assign m_sclk[0]  = bus0.spi_clock;
    assign m_sd[0]    = bus0.spi_data;
    assign m_done[0]  = bus0.tx_done;
    assign m_ready[0] = bus0.tx_ready;
    assign m_cs[1]    = bus1.spi_cs;
    assign m_sclk[1]  = bus1.spi_clock;
    assign m_sd[1]    = bus1.spi_data;
    assign m_done[1]  = bus1.tx_done;
    assign m_ready[1] = bus1.tx_ready;

    logic [23:0] exp_q0[$];
    logic [23:0] exp_q1[$];

    int          frames_done[2] = '{0, 0};
    int          done_cnt[2]    = '{0, 0};
    int          edges_live[2]  = '{0, 0};
    int          last_gap[2]    = '{0, 0};
    bit          abort_pend[2]  = '{0, 0};
    logic [23:0] last_word[2];

    // Frame sampler for one instance; samples on the falling sys_clk edge.
    task automatic mon(input int id);
        int          cd   = (id == 0) ? 4 : 3;
        int          flen = (id == 0) ? 196 : 147;
        logic        pcs = 1'b1, psclk = 1'b0, psd = 1'b0;
        logic        cs, sclk, sd;
        bit          in_frame = 0, seen_end = 0;
        int          low_cnt = 0, high_cnt = 0;
        int          since_data = 0, since_rise = 1000;
        int          stab_viol = 0, ready_viol = 0;
        int          qsize;
        logic [23:0] word = '0;
        logic [23:0] expw;
        forever begin
            @(negedge sys_clk);
            cs   = m_cs[id];
            sclk = m_sclk[id];
            sd   = m_sd[id];
            if (m_done[id]) done_cnt[id]++;
            if (pcs && !cs) begin
                in_frame = 1; low_cnt = 1; edges_live[id] = 0; word = '0;
                since_data = 0; since_rise = 1000; stab_viol = 0; ready_viol = 0;
                if (seen_end) last_gap[id] = high_cnt;
                if (m_ready[id]) ready_viol++;
            end else if (in_frame && !cs) begin
                low_cnt++;
                since_data++;
                if (since_rise < 1000) since_rise++;
                if (m_ready[id]) ready_viol++;
                if (sclk && !psclk) begin
                    if (since_data < cd) stab_viol++;
                    edges_live[id]++;
                    word = {word[22:0], sd};
                    since_rise = 0;
                end
                if (sd != psd) begin
                    if (since_rise < cd) stab_viol++;
                    since_data = 0;
                end
            end else if (in_frame && cs) begin
                in_frame = 0; seen_end = 1; high_cnt = 1;
                qsize = (id == 0) ? exp_q0.size() : exp_q1.size();
                check_eq($sformatf("d%0d_sb_has_entry", id), 32'(qsize > 0), 32'd1);
                expw = '0;
                if (qsize > 0) expw = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                if (abort_pend[id]) begin
                    check_eq($sformatf("d%0d_abort_no_done", id), 32'(m_done[id]), 32'd0);
                    abort_pend[id] = 0;
                end else begin
                    check_eq($sformatf("d%0d_word", id), 32'(word), 32'(expw));
                    check_eq($sformatf("d%0d_rise_edges", id), 32'(edges_live[id]), 32'd24);
                    check_eq($sformatf("d%0d_cs_low_cycles", id), 32'(low_cnt), 32'(flen));
                    check_eq($sformatf("d%0d_done_at_cs_rise", id), 32'(m_done[id]), 32'd1);
                    check_eq($sformatf("d%0d_data_stability", id), 32'(stab_viol), 32'd0);
                    check_eq($sformatf("d%0d_ready_low_in_frame", id), 32'(ready_viol), 32'd0);
                    last_word[id] = word;
                    $display("frame d%0d word=%06h exp=%06h edges=%0d low=%0d",
                             id, word, expw, edges_live[id], low_cnt);
                end
                frames_done[id]++;
            end else if (cs) begin
                high_cnt++;
            end
            pcs = cs; psclk = sclk; psd = sd;
        end
    endtask

    task automatic drive(input int id, input logic v, input logic [23:0] d);
        if (id == 0) begin bus0.tx_valid = v; bus0.tx_data = d; end
        else         begin bus1.tx_valid = v; bus1.tx_data = d; end
    endtask

    task automatic push_exp(input int id, input logic [23:0] e);
        if (id == 0) exp_q0.push_back(e);
        else         exp_q1.push_back(e);
    endtask

    task automatic wait_ready(input int id);
        int n = 0;
        @(negedge sys_clk);
        while (!m_ready[id] && n < 1000) begin
            @(negedge sys_clk);
            n++;
        end
        check_eq($sformatf("d%0d_ready_wait", id), 32'(m_ready[id]), 32'd1);
    endtask

    task automatic send(input int id, input logic [23:0] w, input logic [23:0] e);
        wait_ready(id);
        drive(id, 1'b1, w);
        push_exp(id, e);
        @(posedge sys_clk);
        @(negedge sys_clk);
        drive(id, 1'b0, w);
    endtask

    task automatic wait_frames(input int id, input int n);
        int k = 0;
        while (frames_done[id] < n && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        check_eq($sformatf("d%0d_frames", id), 32'(frames_done[id]), 32'(n));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog sim_time got=expired exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;
        int done_before;
        rst0 = 1'b1;
        rst1 = 1'b1;
        drive(0, 1'b0, 24'h0);
        drive(1, 1'b0, 24'h0);
        fork
            mon(0);
            mon(1);
        join_none

        // Reset values while reset is held
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("rst_cs",      32'(bus0.spi_cs),    32'd1);
        check_eq("rst_clock",   32'(bus0.spi_clock), 32'd0);
        check_eq("rst_data",    32'(bus0.spi_data),  32'd0);
        check_eq("rst_ready",   32'(bus0.tx_ready),  32'd1);
        check_eq("rst_busy",    32'(bus0.busy),      32'd0);
        check_eq("rst_done",    32'(bus0.tx_done),   32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Idle steady for 500 cycles with tx_valid low
        bad = 0;
        repeat (500) begin
            @(negedge sys_clk);
            if (bus0.spi_cs !== 1'b1 || bus0.spi_clock !== 1'b0 || bus0.tx_ready !== 1'b1) bad++;
        end
        check_eq("idle_steady", 32'(bad), 32'd0);

        // Frequency divider word
        send(0, mk_freq_cmd(17'd13000), 24'h0032C8);
        wait_frames(0, 1);
        check_eq("freq_done_pulses", 32'(done_cnt[0]), 32'd1);

        // Seed load word
        send(0, mk_seed_cmd(23'h01B207), 24'h81B207);
        wait_frames(0, 2);
        check_eq("seed_cmd_bit", 32'(last_word[0][23]),   32'd1);
        check_eq("seed_payload", 32'(last_word[0][22:0]), 32'h01B207);

        // Back-to-back with tx_valid held high
        wait_ready(0);
        drive(0, 1'b1, 24'hAAAAAA);
        push_exp(0, 24'hAAAAAA);
        @(posedge sys_clk);
        @(negedge sys_clk);
        drive(0, 1'b1, 24'h555555);
        push_exp(0, 24'h555555);
        n = 0;
        while (!m_ready[0] && n < 1000) begin
            @(negedge sys_clk);
            n++;
        end
        check_eq("b2b_second_ready", 32'(m_ready[0]), 32'd1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        drive(0, 1'b0, 24'h555555);
        wait_frames(0, 4);
        check_eq("b2b_cs_high_gap", 32'(last_gap[0]), 32'd5);

        // Reset at bit 10 of a frame
        done_before = done_cnt[0];
        send(0, 24'h3C3C3C, 24'h3C3C3C);
        n = 0;
        while (edges_live[0] < 10 && n < 1000) begin
            @(negedge sys_clk);
            n++;
        end
        check_eq("abort_reached_bit10", 32'(edges_live[0] >= 10), 32'd1);
        abort_pend[0] = 1;
        rst0 = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("abort_cs_high",  32'(bus0.spi_cs), 32'd1);
        check_eq("abort_busy_low", 32'(bus0.busy),   32'd0);
        rst0 = 1'b0;
        wait_frames(0, 5);
        repeat (10) @(negedge sys_clk);
        check_eq("abort_no_done_pulse", 32'(done_cnt[0]), 32'(done_before));
        send(0, 24'h000100, 24'h000100);
        wait_frames(0, 6);
        check_eq("after_abort_done_pulses", 32'(done_cnt[0]), 32'(done_before + 1));

        // CLK_DIV=3, GAP_CYC=1 instance
        send(1, 24'hA5C3F0, 24'hA5C3F0);
        send(1, 24'h0F0F0F, 24'h0F0F0F);
        wait_frames(1, 2);
        check_eq("d1_done_pulses", 32'(done_cnt[1]), 32'd2);

        repeat (20) @(negedge sys_clk);
        check_eq("sb0_drained", 32'(exp_q0.size()), 32'd0);
        check_eq("sb1_drained", 32'(exp_q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
